// File: rtl/i2c_reg_responder_pkg.sv
// Shared types and constants for the I2C register responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_reg_responder_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_ACK_DEV,
    S_REG,
    S_ACK_REG,
    S_WDATA,
    S_ACK_WR,
    S_RDATA,
    S_ACK_RD,
    S_IGNORE
  } i2c_state_e;

  // SDA level of an acknowledge bit (low) and a not-acknowledge (released high).
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit counter must hold 0..8 (eight data bits plus the "byte done" count).
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_reg_responder_if.sv
// I2C pad-side signals of the responder: pad inputs and open-drain SDA enable.
// Latency: n/a (wiring only).
// Backpressure: none; SCL is never driven, so no clock stretching.
interface i2c_reg_responder_if;
  logic sda_in;
  logic scl_in;
  logic sda_oen;

  modport slave (input sda_in, input scl_in, output sda_oen);
  modport master (output sda_in, output scl_in, input sda_oen);
endinterface

// File: rtl/i2c_reg_responder_bus_sync.sv
// Synchronizes SDA/SCL, optionally glitch-filters them, and flags SCL edges and START/STOP.
// Latency: 3 clk from pad to event (plus FILTER_LEN clk with I2C_RESPONDER_GLITCH_FILTER_EN).
// Backpressure: none; events are single-cycle pulses.
module i2c_reg_responder_bus_sync #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sda_in,
  input  logic scl_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] sda_sync_q, sda_sync_d, scl_sync_q, scl_sync_d;
  logic       sda_prev_q, sda_prev_d, scl_prev_q, scl_prev_d;
  logic       sda_flt, scl_flt;

`ifdef I2C_RESPONDER_GLITCH_FILTER_EN
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CNT_W-1:0] sda_cnt_q, sda_cnt_d, scl_cnt_q, scl_cnt_d;
  logic             sda_flt_q, sda_flt_d, scl_flt_q, scl_flt_d;

  // A new level is accepted only after FILTER_LEN consecutive samples disagree with the held one.
  always_comb begin
    sda_flt_d = sda_flt_q;
    sda_cnt_d = '0;
    scl_flt_d = scl_flt_q;
    scl_cnt_d = '0;
    if (sda_sync_q[1] != sda_flt_q) begin
      if (sda_cnt_q == CNT_W'(FILTER_LEN - 1)) sda_flt_d = sda_sync_q[1];
      else                                     sda_cnt_d = sda_cnt_q + 1'b1;
    end
    if (scl_sync_q[1] != scl_flt_q) begin
      if (scl_cnt_q == CNT_W'(FILTER_LEN - 1)) scl_flt_d = scl_sync_q[1];
      else                                     scl_cnt_d = scl_cnt_q + 1'b1;
    end
  end

  // Filter state; the bus idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sda_flt_q <= 1'b1;
      scl_flt_q <= 1'b1;
      sda_cnt_q <= '0;
      scl_cnt_q <= '0;
    end else begin
      sda_flt_q <= sda_flt_d;
      scl_flt_q <= scl_flt_d;
      sda_cnt_q <= sda_cnt_d;
      scl_cnt_q <= scl_cnt_d;
    end
  end

  assign sda_flt = sda_flt_q;
  assign scl_flt = scl_flt_q;
`else
  // FILTER_LEN has no effect without the glitch filter.
  localparam int unused_filter_len = FILTER_LEN;

  assign sda_flt = sda_sync_q[1];
  assign scl_flt = scl_sync_q[1];
`endif

  // Shift pads into the synchronizers and remember the previous conditioned levels.
  always_comb begin
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_prev_d = sda_flt;
    scl_prev_d = scl_flt;
  end

  // Synchronizer and edge-history registers; reset to the idle-high bus level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sda_sync_q <= 2'b11;
      scl_sync_q <= 2'b11;
      sda_prev_q <= 1'b1;
      scl_prev_q <= 1'b1;
    end else begin
      sda_sync_q <= sda_sync_d;
      scl_sync_q <= scl_sync_d;
      sda_prev_q <= sda_prev_d;
      scl_prev_q <= scl_prev_d;
    end
  end

  assign scl_rise  = scl_flt & ~scl_prev_q;
  assign scl_fall  = ~scl_flt & scl_prev_q;
  assign start_det = scl_flt & scl_prev_q & sda_prev_q & ~sda_flt;
  assign stop_det  = scl_flt & scl_prev_q & ~sda_prev_q & sda_flt;
  assign sda_s     = sda_flt;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C target exposing a 256x8 register file at CHIP_ADDR, with a local read-only host port.
// Latency: SDA driven 1 clk after detected SCL fall; host_rdata 1 clk after host_addr.
// Backpressure: none; no clock stretching. Glitch filter via I2C_RESPONDER_GLITCH_FILTER_EN.
module i2c_reg_responder
  import i2c_reg_responder_pkg::*;
#(
  parameter logic [6:0] CHIP_ADDR  = 7'h39,
  parameter int         FILTER_LEN = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  i2c_reg_responder_if.slave        bus,
  output logic                      busy,
  output logic                      wr_strobe,
  output logic [7:0]                wr_addr,
  output logic [7:0]                wr_data,
  input  logic [7:0]                host_addr,
  output logic [7:0]                host_rdata
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_reg_responder_bus_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sda_in    (bus.sda_in),
    .scl_in    (bus.scl_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d, ptr_q, ptr_d;
  logic                 ack_ph_q, ack_ph_d;
  logic                 sda_oen_q, sda_oen_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0]           wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, host_rdata_q, host_rdata_d;
  logic [7:0]           regs_q [256];
  logic                 mem_we;
  logic [7:0]           rx_byte, rd_byte;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign rd_byte = regs_q[ptr_q];

  // Protocol FSM: START/STOP take priority, then per-state SCL-edge handling.
  // ack_ph marks the second half of an ACK slot (target driving, or master ACK seen).
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    ack_ph_d     = ack_ph_q;
    sda_oen_d    = sda_oen_q;
    busy_d       = busy_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    mem_we       = 1'b0;
    host_rdata_d = regs_q[host_addr];
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oen_d = 1'b1;
      busy_d    = 1'b0;
      ack_ph_d  = 1'b0;
    end else if (start_det) begin
      state_d   = S_DEV;
      bit_cnt_d = '0;
      sda_oen_d = 1'b1;
      ack_ph_d  = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_REG, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              bit_cnt_d = '0;
              case (state_q)
                S_DEV: begin
                  if (rx_byte[7:1] == CHIP_ADDR) begin
                    state_d = S_ACK_DEV;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = S_IGNORE;
                  end
                end
                S_REG: begin
                  ptr_d   = rx_byte;
                  state_d = S_ACK_REG;
                end
                default: begin
                  mem_we      = 1'b1;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = ptr_q;
                  wr_data_d   = rx_byte;
                  ptr_d       = ptr_q + 8'd1;
                  state_d     = S_ACK_WR;
                end
              endcase
            end
          end
        end
        S_ACK_DEV, S_ACK_REG, S_ACK_WR: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oen_d = I2C_ACK;
              ack_ph_d  = 1'b1;
            end else begin
              ack_ph_d  = 1'b0;
              sda_oen_d = 1'b1;
              // shift_q[0] still holds the R/W bit of the device byte.
              if (state_q == S_ACK_DEV && shift_q[0]) begin
                shift_d   = rd_byte;
                sda_oen_d = rd_byte[7];
                state_d   = S_RDATA;
              end else if (state_q == S_ACK_DEV) begin
                state_d = S_REG;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt_q == BIT_CNT_W'(8)) begin
              sda_oen_d = 1'b1;
              ptr_d     = ptr_q + 8'd1;
              bit_cnt_d = '0;
              state_d   = S_ACK_RD;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oen_d = shift_q[6];
            end
          end
        end
        S_ACK_RD: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) state_d = S_IGNORE;
            else                   ack_ph_d = 1'b1;
          end else if (scl_fall && ack_ph_q) begin
            ack_ph_d  = 1'b0;
            shift_d   = rd_byte;
            sda_oen_d = rd_byte[7];
            state_d   = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      ack_ph_q     <= 1'b0;
      sda_oen_q    <= 1'b1;
      busy_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      ack_ph_q     <= ack_ph_d;
      sda_oen_q    <= sda_oen_d;
      busy_q       <= busy_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Register file; host reads in the same cycle as a write see the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= '0;
    end else if (mem_we) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  assign bus.sda_oen = sda_oen_q;
  assign busy        = busy_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Self-checking bench for i2c_reg_responder: bit-banged I2C master, write/read scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_reg_responder;
  import i2c_reg_responder_pkg::*;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_sda = 1'b1;
  logic       m_scl = 1'b1;
  logic       busy, wr_strobe;
  logic [7:0] wr_addr, wr_data, host_rdata;
  logic [7:0] host_addr = 8'h00;

  always #5 clk = ~clk;

  i2c_reg_responder_if bus_if ();
  assign bus_if.sda_in = m_sda & bus_if.sda_oen;  // open-drain wired-AND
  assign bus_if.scl_in = m_scl;

  i2c_reg_responder dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus_if),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .host_addr  (host_addr),
    .host_rdata (host_rdata)
  );

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] dev; logic [7:0] ra; logic [7:0] wd; logic ack; } wvec_t;

  int         n_vec = 0;
  int         n_miss = 0;
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] mem_model [256];
  logic [7:0] host_at_strobe = 8'h00;
  logic       watch_nodrive = 1'b0;
  int         nodrive_viol = 0;
  int         busy_viol = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = bus_if.sda_in;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    acked = (b == I2C_ACK);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(master_ack);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back('{a: a, d: d});
    mem_model[a] = d;
  endtask

  task automatic read_chk(input string nm, input logic master_ack);
    logic [7:0] got, exp;
    read_byte(master_ack, got);
    exp = rd_q.pop_front();
    check(nm, got, exp);
  endtask

  task automatic host_chk(input string nm, input logic [7:0] a);
    host_addr = a;
    tick(1);
    check(nm, host_rdata, mem_model[a]);
  endtask

  // Write scoreboard and bus watchers.
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      wr_t e;
      host_at_strobe = host_rdata;
      check("wr_strobe_expected", wr_q.size() != 0, 1'b1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("wr_addr", wr_addr, e.a);
        check("wr_data", wr_data, e.d);
      end
    end
    if (watch_nodrive) begin
      if (!bus_if.sda_oen) nodrive_viol++;
      if (busy) busy_viol++;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run still active, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t      vecs [7];
    logic       acked;
    logic [7:0] old;

    vecs[0] = '{dev: 8'h72, ra: 8'h41, wd: 8'h10, ack: 1'b1};
    vecs[1] = '{dev: 8'h72, ra: 8'h42, wd: 8'h20, ack: 1'b1};
    vecs[2] = '{dev: 8'h74, ra: 8'h43, wd: 8'h55, ack: 1'b0};
    vecs[3] = '{dev: 8'h72, ra: 8'h00, wd: 8'hFF, ack: 1'b1};
    vecs[4] = '{dev: 8'h70, ra: 8'h41, wd: 8'h99, ack: 1'b0};
    vecs[5] = '{dev: 8'h72, ra: 8'h80, wd: 8'h5A, ack: 1'b1};
    vecs[6] = '{dev: 8'hE4, ra: 8'h42, wd: 8'h77, ack: 1'b0};
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;

    // Reset state.
    tick(3);
    check("rst_sda_oen", bus_if.sda_oen, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_host_rdata", host_rdata, 8'h00);
    rst_n = 1'b1;
    tick(5);
    host_chk("rst_reg41", 8'h41);

    // Single-byte write transactions, matching and non-matching device bytes.
    for (int v = 0; v < 7; v++) begin
      nodrive_viol  = 0;
      busy_viol     = 0;
      watch_nodrive = !vecs[v].ack;
      i2c_start();
      write_byte(vecs[v].dev, acked);
      check($sformatf("v%0d_dev_ack", v), acked, vecs[v].ack);
      check($sformatf("v%0d_busy", v), busy, vecs[v].ack);
      if (vecs[v].ack) push_wr(vecs[v].ra, vecs[v].wd);
      write_byte(vecs[v].ra, acked);
      check($sformatf("v%0d_reg_ack", v), acked, vecs[v].ack);
      write_byte(vecs[v].wd, acked);
      check($sformatf("v%0d_data_ack", v), acked, vecs[v].ack);
      i2c_stop();
      watch_nodrive = 1'b0;
      check($sformatf("v%0d_busy_after_stop", v), busy, 1'b0);
      if (!vecs[v].ack) begin
        check($sformatf("v%0d_sda_never_driven", v), nodrive_viol, 0);
        check($sformatf("v%0d_busy_never_set", v), busy_viol, 0);
      end
      host_chk($sformatf("v%0d_host_read", v), vecs[v].ra);
    end

    // Combined format: set pointer 0x41, repeated START, read two bytes.
    i2c_start();
    write_byte(8'h72, acked);
    write_byte(8'h41, acked);
    i2c_start();
    write_byte(8'h73, acked);
    check("comb_rd_dev_ack", acked, 1'b1);
    rd_q.push_back(mem_model[8'h41]);
    rd_q.push_back(mem_model[8'h42]);
    read_chk("comb_rd_byte0", I2C_ACK);
    read_chk("comb_rd_byte1", I2C_NACK);
    check("comb_sda_released_after_nack", bus_if.sda_oen, 1'b1);
    i2c_stop();

    // Burst write wrapping past 0xFF, then burst read across the wrap.
    i2c_start();
    write_byte(8'h72, acked);
    write_byte(8'hFE, acked);
    push_wr(8'hFE, 8'hA1);
    push_wr(8'hFF, 8'hA2);
    push_wr(8'h00, 8'hA3);
    write_byte(8'hA1, acked);
    write_byte(8'hA2, acked);
    write_byte(8'hA3, acked);
    check("burst_last_ack", acked, 1'b1);
    i2c_stop();
    host_chk("burst_reg_fe", 8'hFE);
    host_chk("burst_reg_ff", 8'hFF);
    host_chk("burst_reg_00", 8'h00);
    i2c_start();
    write_byte(8'h72, acked);
    write_byte(8'hFF, acked);
    i2c_start();
    write_byte(8'h73, acked);
    rd_q.push_back(mem_model[8'hFF]);
    rd_q.push_back(mem_model[8'h00]);
    read_chk("wrap_rd_ff", I2C_ACK);
    read_chk("wrap_rd_00", I2C_NACK);
    i2c_stop();

    // STOP after four data bits: partial byte discarded.
    i2c_start();
    write_byte(8'h72, acked);
    write_byte(8'h30, acked);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    i2c_stop();
    tick(4);
    check("partial_busy", busy, 1'b0);
    check("partial_sda_oen", bus_if.sda_oen, 1'b1);
    host_chk("partial_reg30", 8'h30);
    // Following write works; host read of the same address during the write sees the old value.
    old = mem_model[8'h30];
    i2c_start();
    write_byte(8'h72, acked);
    write_byte(8'h30, acked);
    push_wr(8'h30, 8'h66);
    write_byte(8'h66, acked);
    check("after_partial_data_ack", acked, 1'b1);
    i2c_stop();
    check("host_old_value_on_write", host_at_strobe, old);
    host_chk("after_partial_reg30", 8'h30);

    // Reset while the responder drives a 0 bit of read data (reg 0x40 is 0x00).
    i2c_start();
    write_byte(8'h72, acked);
    write_byte(8'h40, acked);
    i2c_start();
    write_byte(8'h73, acked);
    tick(2);
    check("rd_driving_low", bus_if.sda_oen, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sda_oen", bus_if.sda_oen, 1'b1);
    check("rst_mid_host_rdata", host_rdata, 8'h00);
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    tick(5);
    check("rst_mid_busy", busy, 1'b0);
    host_chk("rst_mid_reg41", 8'h41);
    host_chk("rst_mid_regfe", 8'hFE);
    host_chk("rst_mid_reg30", 8'h30);
    check("wr_queue_drained", wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
